// File: rtl/jedro_1_defines.sv
// Shared widths and types for the jedro_1 data-RAM responder.
package jedro_1_defines;

  localparam int DATA_WIDTH   = 32;
  localparam int RAM_BE_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } ram_state_e;

endpackage

// File: rtl/jedro_1_ram_array.sv
// Synchronous single-port DEPTH_WORDS x 32 storage with per-byte write enables.
module jedro_1_ram_array
  import jedro_1_defines::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                             clk,
  input  logic                             en,
  input  logic                             we,
  input  logic [RAM_BE_WIDTH-1:0]          be,
  input  logic [$clog2(DEPTH_WORDS)-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  output logic [DATA_WIDTH-1:0]            rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < RAM_BE_WIDTH; i++) begin
        if (we && be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/jedro_1_dataram.sv
// Data-RAM responder: latches a request, waits WAIT_STATES cycles, then acks once.
module jedro_1_dataram
  import jedro_1_defines::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [RAM_BE_WIDTH-1:0] be_i,
  input  logic [31:0]             addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    ack_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  ram_state_e              state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic                    load;
  logic                    we_q;
  logic [RAM_BE_WIDTH-1:0] be_q;
  logic [31:0]             addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    ack_q, err_q, rd_vld_q;

  logic [31:0]             offset;
  logic                    in_range, err_cond, fire, arr_en;
  logic [DATA_WIDTH-1:0]   arr_rdata;

  // Base is aligned to the span, so a plain subtract gives the in-window offset.
  assign offset   = addr_q - BASE_ADDR;
  assign in_range = (addr_q >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign err_cond = (addr_q[1:0] != 2'b00) || !in_range || (be_q == '0);
  assign fire     = (state == RESP);
  assign arr_en   = fire && !err_cond;

  jedro_1_ram_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk_i),
    .en    (arr_en),
    .we    (we_q),
    .be    (be_q),
    .addr  (offset[AW+1:2]),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (req_i) begin
          load = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The response is registered: ack rises on the same edge the array commits/reads.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      if (load) begin
        we_q    <= we_i;
        be_q    <= be_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      ack_q    <= fire;
      err_q    <= fire && err_cond;
      rd_vld_q <= fire && !err_cond && !we_q;
    end
  end

  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rdata_o = rd_vld_q ? arr_rdata : '0;

endmodule

// File: tb/tb_jedro_1_dataram.sv
// Bench for jedro_1_dataram: three instances (0, 3 and 5 wait states) against a word-array model.
module tb_jedro_1_dataram;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req   [3];
  logic        we    [3];
  logic [3:0]  be    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        ack   [3];
  logic        err   [3];

  int checks   = 0;
  int failures = 0;

  int     ws_of    [3] = '{0, 3, 5};
  longint base_of  [3] = '{0, 64'h8000_0000, 0};
  longint depth_of [3] = '{1024, 256, 1024};

  logic [31:0] mdl [longint];

  always #5 clk = ~clk;

  jedro_1_dataram #(.WAIT_STATES(0)) u0 (
    .clk_i(clk), .rstn_i(rstn), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .ack_o(ack[0]), .rdata_o(rdata[0]), .err_o(err[0]));

  jedro_1_dataram #(.DEPTH_WORDS(256), .WAIT_STATES(3), .BASE_ADDR(32'h8000_0000)) u1 (
    .clk_i(clk), .rstn_i(rstn), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .ack_o(ack[1]), .rdata_o(rdata[1]), .err_o(err[1]));

  jedro_1_dataram #(.WAIT_STATES(5)) u2 (
    .clk_i(clk), .rstn_i(rstn), .req_i(req[2]), .we_i(we[2]), .be_i(be[2]),
    .addr_i(addr[2]), .wdata_i(wdata[2]), .ack_o(ack[2]), .rdata_o(rdata[2]), .err_o(err[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Full handshake; lat counts edges from the accepting edge to the one that raises ack.
  task automatic txn(input int d, input bit w, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] wd, output int lat, output logic [31:0] rd,
                     output logic e);
    bit got;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
    @(posedge clk);
    lat = 99; rd = '0; e = 1'b0; got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(posedge clk); #1;
      if (ack[d]) begin
        got = 1'b1; lat = c; rd = rdata[d]; e = err[d];
      end
    end
    req[d] = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("ack_pulse_d%0d", d), {31'd0, ack[d]}, 32'd0);
  endtask

  function automatic bit model_err(int d, logic [31:0] a, logic [3:0] b);
    longint off = longint'(a) - base_of[d];
    return (a[1:0] != 2'b00) || (off < 0) || (off >= 4 * depth_of[d]) || (b == 4'b0000);
  endfunction

  function automatic longint model_key(int d, logic [31:0] a);
    return longint'(d) * 4096 + (longint'(a) - base_of[d]) / 4;
  endfunction

  // Applies one transaction to the model and returns the expected rdata/err.
  function automatic void model_txn(int d, bit w, logic [3:0] b, logic [31:0] a,
                                    logic [31:0] wd, output logic [31:0] er, output bit ee);
    longint k;
    logic [31:0] cur;
    ee = model_err(d, a, b);
    er = '0;
    if (ee) return;
    k = model_key(d, a);
    cur = mdl.exists(k) ? mdl[k] : 32'h0;
    if (w) begin
      for (int i = 0; i < 4; i++) if (b[i]) cur[8*i +: 8] = wd[8*i +: 8];
      mdl[k] = cur;
    end else begin
      er = cur;
    end
  endfunction

  typedef struct {
    int          d;
    bit          w;
    logic [3:0]  b;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] er;
    bit          ee;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl [$];
    int          lat, cnt;
    logic [31:0] rd, er, pool [2][8];
    logic        e;
    bit          ee, got;

    rstn = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req[d] = 0; we[d] = 0; be[d] = 0; addr[d] = 0; wdata[d] = 0;
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_ack_d%0d", d), {31'd0, ack[d]}, 32'd0);
      chk($sformatf("reset_err_d%0d", d), {31'd0, err[d]}, 32'd0);
      chk($sformatf("reset_rdata_d%0d", d), rdata[d], 32'd0);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    tbl.push_back('{0, 1, 4'hF, 32'h10,        32'hDEADBEEF, 32'h0,        0});
    tbl.push_back('{0, 0, 4'hF, 32'h10,        32'h0,        32'hDEADBEEF, 0});
    tbl.push_back('{0, 1, 4'hF, 32'h20,        32'h11223344, 32'h0,        0});
    tbl.push_back('{0, 1, 4'h4, 32'h20,        32'hAABBCCDD, 32'h0,        0});
    tbl.push_back('{0, 0, 4'h1, 32'h20,        32'h0,        32'h11BB3344, 0});
    tbl.push_back('{0, 1, 4'hF, 32'h2,         32'hFFFFFFFF, 32'h0,        1});
    tbl.push_back('{0, 1, 4'hF, 32'h1000,      32'hFFFFFFFF, 32'h0,        1});
    tbl.push_back('{0, 1, 4'h0, 32'h20,        32'hFFFFFFFF, 32'h0,        1});
    tbl.push_back('{0, 0, 4'hF, 32'h1000,      32'h0,        32'h0,        1});
    tbl.push_back('{0, 0, 4'hF, 32'h13,        32'h0,        32'h0,        1});
    tbl.push_back('{0, 0, 4'hF, 32'h20,        32'h0,        32'h11BB3344, 0});
    tbl.push_back('{1, 1, 4'hF, 32'h8000_03FC, 32'h55AA55AA, 32'h0,        0});
    tbl.push_back('{1, 1, 4'hF, 32'h8000_0000, 32'h0BADF00D, 32'h0,        0});
    tbl.push_back('{1, 0, 4'hF, 32'h8000_03FC, 32'h0,        32'h55AA55AA, 0});
    tbl.push_back('{1, 0, 4'hF, 32'h8000_0400, 32'h0,        32'h0,        1});
    tbl.push_back('{1, 0, 4'hF, 32'h7FFF_FFFC, 32'h0,        32'h0,        1});
    tbl.push_back('{1, 0, 4'hF, 32'h0000_03FC, 32'h0,        32'h0,        1});
    tbl.push_back('{2, 1, 4'hF, 32'h40,        32'h01020304, 32'h0,        0});
    tbl.push_back('{2, 0, 4'hF, 32'h40,        32'h0,        32'h01020304, 0});

    foreach (tbl[i]) begin
      txn(tbl[i].d, tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].wd, lat, rd, e);
      model_txn(tbl[i].d, tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].wd, er, ee);
      chk($sformatf("vec%0d_latency", i), lat, ws_of[tbl[i].d] + 1);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].er);
      chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, tbl[i].ee});
    end

    // Read on the 3-wait-state instance while req and fields wiggle during WAIT.
    @(negedge clk);
    req[1] = 1; we[1] = 0; be[1] = 4'hF; addr[1] = 32'h8000_03FC; wdata[1] = 0;
    @(posedge clk);
    lat = 99; rd = 0; got = 0;
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge clk);
      req[1] = c[0]; we[1] = 1; addr[1] = 32'h8000_0000; wdata[1] = 32'h12345678;
      @(posedge clk); #1;
      if (ack[1]) begin got = 1; lat = c; rd = rdata[1]; end
    end
    req[1] = 0;
    chk("toggle_latency", lat, 4);
    chk("toggle_rdata", rd, 32'h55AA55AA);
    @(posedge clk); #1;
    chk("toggle_ack_pulse", {31'd0, ack[1]}, 32'd0);
    txn(1, 0, 4'hF, 32'h8000_0000, 0, lat, rd, e);
    chk("toggle_no_write", rd, 32'h0BADF00D);

    // Reset while instance 2 has a write in WAIT and instance 0 is mid-ack.
    @(negedge clk);
    req[2] = 1; we[2] = 1; be[2] = 4'hF; addr[2] = 32'h40; wdata[2] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    @(negedge clk);
    req[0] = 1; we[0] = 0; be[0] = 4'hF; addr[0] = 32'h10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_pre_ack", {31'd0, ack[0]}, 32'd1);
    chk("rst_pre_rdata", rdata[0], 32'hDEADBEEF);
    req[0] = 0;
    #2 rstn = 1'b0;
    #1;
    chk("rst_async_ack", {31'd0, ack[0]}, 32'd0);
    chk("rst_async_rdata", rdata[0], 32'd0);
    chk("rst_async_err", {31'd0, err[0]}, 32'd0);
    req[2] = 0;
    @(negedge clk);
    rstn = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ack[0] || ack[1] || ack[2]) cnt++;
    end
    chk("rst_no_ack_after", cnt, 0);
    txn(2, 0, 4'hF, 32'h40, 0, lat, rd, e);
    chk("rst_word_kept", rd, 32'h01020304);
    chk("rst_readback_latency", lat, 6);

    // Randomised traffic against the model over a small pool of words.
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < 8; j++) begin
        pool[d][j] = 32'(base_of[d] + 4 * ((j * 29 + 3) % depth_of[d]));
        er = $urandom;
        txn(d, 1, 4'hF, pool[d][j], er, lat, rd, e);
        model_txn(d, 1, 4'hF, pool[d][j], er, er, ee);
      end
    end
    for (int n = 0; n < 60; n++) begin
      int          d;
      bit          w;
      logic [3:0]  b;
      logic [31:0] a, wd;
      d  = $urandom_range(0, 1);
      w  = $urandom_range(0, 1);
      b  = 4'($urandom_range(0, 15));
      wd = $urandom;
      a  = pool[d][$urandom_range(0, 7)];
      case ($urandom_range(0, 9))
        0:       a = a + 32'($urandom_range(1, 3));
        1:       a = 32'(base_of[d] + 4 * depth_of[d] + 4 * $urandom_range(0, 3));
        default: ;
      endcase
      txn(d, w, b, a, wd, lat, rd, e);
      model_txn(d, w, b, a, wd, er, ee);
      chk($sformatf("rnd%0d_latency", n), lat, ws_of[d] + 1);
      chk($sformatf("rnd%0d_rdata", n), rd, er);
      chk($sformatf("rnd%0d_err", n), {31'd0, e}, {31'd0, ee});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
